keycode_report_packer: RTL
==========================

# keycode_report_packer

Builds the 4-slot keyboard report consumed by the player keycode selector from a stream of individual key press/release events. Maintains held keys in press order, compacts slots on release, and publishes the report as `keycode`/`keycode0` words in the same format the USB keyboard path delivers. Used for scripted demo playback and for driving the game input path from non-USB sources (PS/2 bridge, testbench).

## Interface
Parameters:
- `NSLOT`, 4: report slots. Fixed at 4; other values unsupported.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high reset.
- `ev_valid` in 1: event offered.
- `ev_ready` out 1: block can accept an event.
- `ev_code` in 8: HID usage code of the event key.
- `ev_press` in 1: 1 = press, 0 = release.
- `keycode` out 16: `[7:0]` slot0, `[15:8]` slot1.
- `keycode0` out 16: `[7:0]` slot2, `[15:8]` slot3.
- `report_update` out 1: one-cycle pulse when the published report is refreshed.
- `rollover` out 1: high while more than 4 keys are held.
- `key_count` out 3: keys held in slots, 0..4.

## Operation
- Internal slot array `slot[0..3]`, count `cnt` (0..4), overflow count `ovf` (0..7, saturating). Slots `>= cnt` are always 0x00.
- Output registers hold the last published report; they change only in PUBLISH, so compaction intermediates are never visible.
- FSM states: IDLE, COMPACT, PUBLISH.
- IDLE: `ev_ready`=1. An event is accepted on an edge where `ev_valid & ev_ready`.
  - Press, `ev_code`==0x00 or already in `slot[0..cnt-1]`: ignored, stay IDLE, no pulse.
  - Press, `cnt`<4: `slot[cnt]`<=`ev_code`, `cnt`++, go to PUBLISH.
  - Press, `cnt`==4: `ovf`++ (saturating at 7), go to PUBLISH.
  - Release, matching slot at index `i`: latch `idx`<=`i`, go to COMPACT.
  - Release, no match, `ovf`>0: `ovf`--, go to PUBLISH.
  - Release, no match, `ovf`==0: ignored, stay IDLE.
- COMPACT: `ev_ready`=0. Each cycle: if `idx`<`cnt`-1 then `slot[idx]`<=`slot[idx+1]`, `idx`++; else `slot[idx]`<=0x00, `cnt`--, go to PUBLISH. This takes `cnt`-`i` cycles.
- Overflow keys are not tracked by identity. Releasing a slotted key while `ovf`>0 compacts normally and leaves `ovf` unchanged.
- PUBLISH: `ev_ready`=0. Load the outputs, pulse `report_update`, return to IDLE.
  - With rollover enabled and `ovf`>0: all four output bytes are 0x01.
  - Otherwise: outputs are `slot[0..3]`.
- `key_count` = `cnt` (registered, tracks internal state). `rollover` = (`ovf`!=0), updated with the outputs in PUBLISH.

## Timing
- Reset: state IDLE; `slot`, `cnt`, `ovf` = 0; `keycode`=`keycode0`=16'h0000; `report_update`=0; `rollover`=0; `key_count`=0; `ev_ready`=1 in the following cycle.
- Reset asserted mid-COMPACT or mid-PUBLISH discards the operation; no `report_update` pulse.
- Press latency: acceptance at edge N → outputs and `report_update` change at edge N+1; `ev_ready` is low during cycle N..N+1 and high again after N+1.
- Release latency: acceptance at edge N → outputs update at edge N+(`cnt`-`i`)+1.
- `ev_ready` is combinational from state (high only in IDLE). Holding `ev_valid` high with a stable event while `ev_ready`=0 is legal; the event is taken on the next IDLE edge.
- Maximum throughput is 1 event per 2 cycles; a worst-case release (`i`=0, `cnt`=4) takes 6 cycles including acceptance.

## Configuration
- `KEYCODE_ROLLOVER_EN` defined: phantom reporting. While `ovf`>0, published bytes are all 0x01 and `rollover` tracks `ovf`.
- Not defined: a 5th+ press is ignored (no `ovf` change, no PUBLISH, no pulse); `rollover` is tied to 0; unmatched releases are always ignored.

## Test plan
- Reset, then press 0x04 → after 2 edges `keycode`=16'h0004, `keycode0`=0, one `report_update` pulse, `key_count`=1.
- Press 0x04, 0x1A, 0x50, 0x4F → `keycode`=16'h1A04, `keycode0`=16'h4F50. Release 0x1A → `keycode`=16'h5004, `keycode0`=16'h004F after 3 COMPACT cycles, `key_count`=3.
- Duplicate press 0x52 while 0x52 is held, and release of unheld 0x07 → no pulse, outputs unchanged, `ev_ready` stays high.
- With `KEYCODE_ROLLOVER_EN`: hold 4 keys, press 0x07 → `keycode`=`keycode0`=16'h0101, `rollover`=1. Release 0x07 → previous 4-key report restored, `rollover`=0.
- Without the macro: same 5th press → no pulse, report unchanged, `rollover`=0.
- Assert `Reset` during COMPACT → next cycle outputs 0, `key_count`=0, `ev_ready`=1, no pulse.

Source files
------------

// File: rtl/keycode_report_packer.sv
// keycode_report_packer: turns a stream of key press/release events into a
// 4-slot keyboard report (keycode = slot1:slot0, keycode0 = slot3:slot2).
// Held keys stay in press order, and a release compacts the slots behind it.
// Optional feature macro: KEYCODE_ROLLOVER_EN (phantom 0x01 reporting while
// more than four keys are held).
module keycode_report_packer #(
  parameter int NSLOT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic [7:0]  ev_code,
  input  logic        ev_press,
  output logic [15:0] keycode,
  output logic [15:0] keycode0,
  output logic        report_update,
  output logic        rollover,
  output logic [2:0]  key_count
);

  typedef enum logic [1:0] {IDLE, COMPACT, PUBLISH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  slot_q [4];
  logic [7:0]  slot_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  ovf_q, ovf_d;
  logic [1:0]  idx_q, idx_d;
  logic        hit;
  logic [1:0]  hit_idx;
  logic [15:0] pub_lo, pub_hi;

  // Locate the event code among the occupied slots (lowest index wins)
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && (3'(i) < cnt_q) && (slot_q[i] == ev_code)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  // Next-state and slot bookkeeping for the IDLE/COMPACT/PUBLISH controller
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    for (int i = 0; i < 4; i++) slot_d[i] = slot_q[i];
    ev_ready = (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (ev_valid) begin
          if (ev_press) begin
            if ((ev_code == 8'h00) || hit) begin
              state_d = IDLE;
            end else if (cnt_q < 3'(NSLOT)) begin
              slot_d[cnt_q[1:0]] = ev_code;
              cnt_d              = cnt_q + 3'd1;
              state_d            = PUBLISH;
            end else begin
`ifdef KEYCODE_ROLLOVER_EN
              if (ovf_q != 3'd7) ovf_d = ovf_q + 3'd1;
              state_d = PUBLISH;
`else
              state_d = IDLE;
`endif
            end
          end else begin
            if (hit) begin
              idx_d   = hit_idx;
              state_d = COMPACT;
            end else begin
`ifdef KEYCODE_ROLLOVER_EN
              if (ovf_q != 3'd0) begin
                ovf_d   = ovf_q - 3'd1;
                state_d = PUBLISH;
              end
`else
              state_d = IDLE;
`endif
            end
          end
        end
      end
      COMPACT: begin
        // Shift one slot down per cycle; the last occupied slot is cleared
        if ({1'b0, idx_q} < (cnt_q - 3'd1)) begin
          slot_d[idx_q] = slot_q[idx_q + 2'd1];
          idx_d         = idx_q + 2'd1;
        end else begin
          slot_d[idx_q] = 8'h00;
          cnt_d         = cnt_q - 3'd1;
          state_d       = PUBLISH;
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Report words to publish: phantom 0x01 bytes while overflowed, else slots
  always_comb begin
    pub_lo = {slot_q[1], slot_q[0]};
    pub_hi = {slot_q[3], slot_q[2]};
`ifdef KEYCODE_ROLLOVER_EN
    if (ovf_q != 3'd0) begin
      pub_lo = 16'h0101;
      pub_hi = 16'h0101;
    end
`endif
  end

  // State, slot storage and published report registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      for (int i = 0; i < 4; i++) slot_q[i] <= 8'h00;
      cnt_q         <= 3'd0;
      ovf_q         <= 3'd0;
      idx_q         <= 2'd0;
      keycode       <= 16'h0000;
      keycode0      <= 16'h0000;
      report_update <= 1'b0;
      rollover      <= 1'b0;
    end else begin
      state_q       <= state_d;
      for (int i = 0; i < 4; i++) slot_q[i] <= slot_d[i];
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      idx_q         <= idx_d;
      report_update <= (state_q == PUBLISH);
      if (state_q == PUBLISH) begin
        keycode  <= pub_lo;
        keycode0 <= pub_hi;
`ifdef KEYCODE_ROLLOVER_EN
        rollover <= (ovf_q != 3'd0);
`else
        rollover <= 1'b0;
`endif
      end
    end
  end

  assign key_count = cnt_q;

endmodule
